// File: rtl/shift_pkg.sv
// shift_pkg: shared constants and FSM state encoding for the shift_norm normalizer.
package shift_pkg;
    localparam int WIDTH_DEF = 32;
    localparam int CW_DEF = 6;
    localparam int SKIP = 4;
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
endpackage

// File: rtl/norm_chk.sv
// norm_chk: normalization, limit and skip-step tests on the value being normalized.
// The 4-bit skip test exists only with SHIFT_NORM_FAST_EN; otherwise can_skip is tied low.
module norm_chk import shift_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW = CW_DEF
) (
    input  logic [WIDTH-1:0] value,
    input  logic             arith,
    input  logic [CW-1:0]    cnt,
    output logic             is_norm,
    output logic             at_limit,
    output logic             can_skip
);
    logic [CW:0] limit, cnt_x;
    assign limit = arith ? (CW+1)'(WIDTH - 1) : (CW+1)'(WIDTH);
    assign cnt_x = {1'b0, cnt};
    assign is_norm = arith ? value[WIDTH-1] ^ value[WIDTH-2] : value[WIDTH-1];
    assign at_limit = cnt_x == limit;
`ifdef SHIFT_NORM_FAST_EN
    // Five equal top bits guarantee the next four single steps would all stay unnormalized.
    assign can_skip = !is_norm && (cnt_x + (CW+1)'(SKIP) <= limit) &&
                      (arith ? (&value[WIDTH-1 -: 5] || ~|value[WIDTH-1 -: 5]) : ~|value[WIDTH-1 -: 4]);
`else
    assign can_skip = 1'b0;
`endif
endmodule

// File: rtl/shift_norm.sv
// shift_norm: multi-cycle CLZ/CLS normalizer with start/busy/done handshake.
// SHIFT_NORM_FAST_EN enables 4-bit skip steps inside norm_chk.
module shift_norm import shift_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sh,
    output logic [CW-1:0]    cnt
);
    logic [1:0] state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d, op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic arith_q, arith_d, accept, stop, step, is_norm, at_limit, can_skip;

    norm_chk #(.WIDTH(WIDTH), .CW(CW)) u_chk (
        .value(sh_q), .arith(arith_q), .cnt(cnt_q),
        .is_norm(is_norm), .at_limit(at_limit), .can_skip(can_skip)
    );

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign stop = is_norm || at_limit;
    assign step = state_q == SHIFT && !stop;

    always_comb begin
        state_d = state_q == LOAD ? SHIFT : state_q == SHIFT ? (stop ? DONE : SHIFT) : accept ? LOAD : IDLE;
        op_d = accept ? d : op_q;
        arith_d = accept ? arith : arith_q;
        sh_d = state_q == LOAD ? op_q : step ? (can_skip ? sh_q << SKIP : sh_q << 1) : sh_q;
        cnt_d = state_q == LOAD ? '0 : step ? cnt_q + (can_skip ? CW'(SKIP) : CW'(1)) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q <= '0;
            op_q <= '0;
            cnt_q <= '0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q <= sh_d;
            op_q <= op_d;
            cnt_q <= cnt_d;
            arith_q <= arith_d;
        end
    end

    assign busy = state_q == LOAD || state_q == SHIFT;
    assign done = state_q == DONE;
    assign sh = sh_q;
    assign cnt = cnt_q;
endmodule

// File: tb/tb_shift_norm.sv
// tb_shift_norm: scoreboard bench for shift_norm (results, latency, handshake, reset abort).
module tb_shift_norm;
    logic clk, rst, start, arith, busy, done;
    logic [31:0] d, sh;
    logic [5:0] cnt;
    int n_chk = 0, n_fail = 0, cyc = 0, dones = 0;

    typedef struct {
        logic [31:0] sh;
        int cnt;
        int lat;
        int t0;
    } ent_t;
    ent_t sbq[$];

    shift_norm #(.WIDTH(32), .CW(6)) dut (
        .clk(clk), .rst(rst), .start(start), .d(d), .arith(arith),
        .busy(busy), .done(done), .sh(sh), .cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t model(logic [31:0] v, bit a);
        ent_t e;
        int lim;
        lim = a ? 31 : 32;
        e.sh = v;
        e.cnt = 0;
        e.lat = 2;
        e.t0 = 0;
        while (e.cnt < lim && !(a ? e.sh[31] != e.sh[30] : e.sh[31])) begin
`ifdef SHIFT_NORM_FAST_EN
            if (e.cnt + 4 <= lim && (a ? (e.sh[31:27] == 5'h00 || e.sh[31:27] == 5'h1f) : e.sh[31:28] == 4'h0)) begin
                e.sh = e.sh << 4;
                e.cnt += 4;
            end else
`endif
            begin
                e.sh = e.sh << 1;
                e.cnt++;
            end
            e.lat++;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        ent_t e;
        if (done) begin
            dones <= dones + 1;
            if (sbq.size() == 0) check("spurious_done", 64'd1, 64'd0);
            else begin
                e = sbq.pop_front();
                check("sh", 64'(sh), 64'(e.sh));
                check("cnt", 64'(cnt), 64'(e.cnt));
                check("latency", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    task automatic wait_dones(input int target);
        for (int i = 0; i < 80 && dones < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (dones < target) begin
            check("timeout", 64'(dones), 64'(target));
            sbq.delete();
        end
    endtask

    task automatic push(input logic [31:0] esh, input int ecnt, input int lb, input int lf,
                        input logic [31:0] dv, input bit a, input int t0);
        ent_t e, m;
        m = model(dv, a);
        e.sh = esh;
        e.cnt = ecnt;
        e.t0 = t0;
`ifdef SHIFT_NORM_FAST_EN
        e.lat = lf < 0 ? m.lat : lf;
`else
        e.lat = lb;
`endif
        sbq.push_back(e);
    endtask

    task automatic op(input logic [31:0] dv, input bit a, input logic [31:0] esh, input int ecnt,
                      input int lb, input int lf);
        int n;
        @(negedge clk);
        d = dv;
        arith = a;
        start = 1'b1;
        push(esh, ecnt, lb, lf, dv, a, cyc + 1);
        n = dones;
        @(negedge clk);
        start = 1'b0;
        wait_dones(n + 1);
    endtask

    initial begin
        ent_t m;
        logic [31:0] dv;
        bit a;
        int n;
        rst = 1'b1;
        start = 1'b0;
        d = '0;
        arith = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sh", 64'(sh), 64'd0);
        check("rst_cnt", 64'(cnt), 64'd0);

        op(32'h0001_0000, 1'b0, 32'h8000_0000, 15, 17, -1);
        op(32'h8000_0001, 1'b0, 32'h8000_0001, 0, 2, 2);
        op(32'h0000_0000, 1'b0, 32'h0000_0000, 32, 34, 10);
        op(32'h0000_0001, 1'b0, 32'h8000_0000, 31, 33, 12);
        op(32'hFFFF_F000, 1'b1, 32'h8000_0000, 19, 21, -1);
        op(32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 31, 33, -1);
        op(32'h0000_0000, 1'b1, 32'h0000_0000, 31, 33, -1);
        op(32'h4000_0000, 1'b1, 32'h4000_0000, 0, 2, 2);

        // back-to-back: start held through DONE, second operand swapped in while busy
        n = dones;
        @(negedge clk);
        d = 32'h8000_0001;
        arith = 1'b0;
        start = 1'b1;
        push(32'h8000_0001, 0, 2, 2, 32'h8000_0001, 1'b0, cyc + 1);
        repeat (2) @(negedge clk);
        d = 32'h4000_0000;
        push(32'h8000_0000, 1, 3, 3, 32'h4000_0000, 1'b0, cyc + 2);
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_dones(n + 2);

        // start pulsed mid-operation with a different operand must be ignored
        n = dones;
        @(negedge clk);
        d = 32'h0001_0000;
        arith = 1'b0;
        start = 1'b1;
        push(32'h8000_0000, 15, 17, -1, 32'h0001_0000, 1'b0, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        d = 32'hFFFF_FFFF;
        arith = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_dones(n + 1);
        repeat (40) @(negedge clk);
        check("ignored_start_dones", 64'(dones), 64'(n + 1));

        // reset in the middle of a long operation
        n = dones;
        @(negedge clk);
        d = 32'h0000_0001;
        arith = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
`ifdef SHIFT_NORM_FAST_EN
        check("mid_cnt", 64'(cnt), 64'd20);
`else
        check("mid_cnt", 64'(cnt), 64'd5);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sh", 64'(sh), 64'd0);
        check("abort_cnt", 64'(cnt), 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(dones), 64'(n));

        for (int i = 0; i < 24; i++) begin
            dv = $urandom >> $urandom_range(0, 31);
            a = 1'($urandom_range(0, 1));
            if (i % 4 == 3) dv = ~dv;
            m = model(dv, a);
            op(dv, a, m.sh, m.cnt, m.lat, -1);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
